uart_packet_decoder: RTL and testbench

Consumes the byte stream and end-of-packet strobe from the UART receive stage. Frames rover command packets: sync byte, length byte, payload, 8-bit additive checksum. Validated payloads are held in a register buffer and presented to the command logic with a valid/ack handshake. Errors are tallied in saturating counters for telemetry.

---
 rtl/uart_packet_decoder_if.sv | 35 +++
 rtl/uart_packet_decoder.sv | 156 +++++++++++++++
 tb/tb_uart_packet_decoder.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_packet_decoder_if.sv
// Byte-stream input, packet handshake, buffer read port and telemetry counters
// between the UART receive stage, the packet decoder and the command logic.
interface uart_packet_decoder_if;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned LEN_W  = 5;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned CNT_W  = 8;

    logic [DATA_W-1:0] rx_data;
    logic              rx_data_ready;
    logic              rx_endofpacket;
    logic              pkt_valid;
    logic              pkt_pending;
    logic [LEN_W-1:0]  pkt_len;
    logic              pkt_ack;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [CNT_W-1:0]  chk_err_cnt;
    logic [CNT_W-1:0]  frame_err_cnt;
    logic [CNT_W-1:0]  overrun_cnt;

    // Byte source and packet consumer side
    modport master (
        output rx_data, rx_data_ready, rx_endofpacket, pkt_ack, rd_addr,
        input  pkt_valid, pkt_pending, pkt_len, rd_data,
        input  chk_err_cnt, frame_err_cnt, overrun_cnt
    );

    // Decoder side
    modport slave (
        input  rx_data, rx_data_ready, rx_endofpacket, pkt_ack, rd_addr,
        output pkt_valid, pkt_pending, pkt_len, rd_data,
        output chk_err_cnt, frame_err_cnt, overrun_cnt
    );
endinterface

// File: rtl/uart_packet_decoder.sv
// Frames rover command packets (sync, length, payload, additive checksum) from
// the UART byte stream, holds the last accepted payload for the command logic
// and tallies framing/checksum/overrun errors in saturating counters.
module uart_packet_decoder #(
    parameter logic [7:0]  SYNC_BYTE = 8'hAA,
    parameter int unsigned MAX_LEN   = 16
) (
    input logic                  clk,
    input logic                  rst,
    uart_packet_decoder_if.slave bus
);
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned LEN_W     = 5;
    localparam int unsigned ADDR_W    = 4;
    localparam int unsigned CNT_W     = 8;
    localparam int unsigned BUF_DEPTH = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        LEN,
        PAYLOAD,
        CHK
    } state_t;

    state_t             state;
    logic [DATA_W-1:0]  sum;
    logic [LEN_W-1:0]   len;
    logic [LEN_W-1:0]   idx;
    logic [DATA_W-1:0]  pktBuf [BUF_DEPTH];

    logic               pktValid;
    logic               pktPending;
    logic [LEN_W-1:0]   pktLen;
    logic [CNT_W-1:0]   chkErrCnt;
    logic [CNT_W-1:0]   frameErrCnt;
    logic [CNT_W-1:0]   overrunCnt;

    logic               lenOk;
    logic               lastPayload;
    logic               abortReq;
    logic [DATA_W-1:0]  chkSum;
    logic               chkPass;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // Frame decode helpers for the byte currently on the bus
    assign lenOk       = (bus.rx_data != '0) && (32'(bus.rx_data) <= MAX_LEN);
    assign lastPayload = (idx == len - LEN_W'(1));
    assign abortReq    = bus.rx_endofpacket && !bus.rx_data_ready;
    assign chkSum      = sum + bus.rx_data;
    assign chkPass     = (chkSum == '0);

    // Framing state machine, payload buffer, handshake and error counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            sum         <= '0;
            len         <= '0;
            idx         <= '0;
            pktValid    <= 1'b0;
            pktPending  <= 1'b0;
            pktLen      <= '0;
            chkErrCnt   <= '0;
            frameErrCnt <= '0;
            overrunCnt  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                pktBuf[i] <= '0;
            end
        end else begin
            pktValid <= 1'b0;

            // A commit only happens when pending was low, so it never races the ack
            if (bus.pkt_ack && pktPending) begin
                pktPending <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (bus.rx_data_ready && (bus.rx_data == SYNC_BYTE)) begin
                        state <= LEN;
                    end
                end

                LEN: begin
                    if (bus.rx_data_ready) begin
                        if (lenOk) begin
                            len   <= LEN_W'(bus.rx_data);
                            sum   <= bus.rx_data;
                            idx   <= '0;
                            state <= PAYLOAD;
                        end else begin
                            frameErrCnt <= satInc(frameErrCnt);
                            state       <= IDLE;
                        end
                    end else if (abortReq) begin
                        frameErrCnt <= satInc(frameErrCnt);
                        state       <= IDLE;
                    end
                end

                PAYLOAD: begin
                    if (bus.rx_data_ready) begin
                        sum <= chkSum;
                        // Held packet stays intact while the consumer owns it
                        if (!pktPending) begin
                            pktBuf[idx[ADDR_W-1:0]] <= bus.rx_data;
                        end
                        idx <= idx + LEN_W'(1);
                        if (lastPayload) begin
                            state <= CHK;
                        end
                    end else if (abortReq) begin
                        frameErrCnt <= satInc(frameErrCnt);
                        state       <= IDLE;
                    end
                end

                CHK: begin
                    if (bus.rx_data_ready) begin
                        if (chkPass) begin
                            if (!pktPending) begin
                                pktLen     <= len;
                                pktPending <= 1'b1;
                                pktValid   <= 1'b1;
                            end else begin
                                overrunCnt <= satInc(overrunCnt);
                            end
                        end else begin
                            chkErrCnt <= satInc(chkErrCnt);
                        end
                        state <= IDLE;
                    end else if (abortReq) begin
                        frameErrCnt <= satInc(frameErrCnt);
                        state       <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    // Registered outputs
    assign bus.pkt_valid     = pktValid;
    assign bus.pkt_pending   = pktPending;
    assign bus.pkt_len       = pktLen;
    assign bus.chk_err_cnt   = chkErrCnt;
    assign bus.frame_err_cnt = frameErrCnt;
    assign bus.overrun_cnt   = overrunCnt;

    // Combinational buffer read port
    assign bus.rd_data = (32'(bus.rd_addr) < MAX_LEN) ? pktBuf[bus.rd_addr] : '0;
endmodule

// File: tb/tb_uart_packet_decoder.sv
// Frame-level randomized bench for uart_packet_decoder: each frame's outcome is
// predicted from its bytes (length range, modulo-256 sum, pending state).
module tb_uart_packet_decoder;
    typedef logic [7:0] byteQueue_t [$];

    localparam logic [7:0] SYNC   = 8'hAA;
    localparam int         MAXLEN = 16;

    logic clk;
    logic rst;

    uart_packet_decoder_if bus ();

    uart_packet_decoder #(
        .SYNC_BYTE (SYNC),
        .MAX_LEN   (MAXLEN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit         mPending;
    int         mLen;
    logic [7:0] mBuf [16];
    int         mChk;
    int         mFrame;
    int         mOvr;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    function automatic logic [7:0] goodChk(input logic [7:0] lenByte, input byteQueue_t pl);
        int s;
        s = int'(lenByte);
        foreach (pl[i]) s += int'(pl[i]);
        return 8'((256 - (s % 256)) % 256);
    endfunction

    task automatic modelReset();
        mPending = 1'b0;
        mLen     = 0;
        foreach (mBuf[i]) mBuf[i] = 8'h00;
        mChk   = 0;
        mFrame = 0;
        mOvr   = 0;
    endtask

    task automatic sendByte(input logic [7:0] b, input bit ack);
        bus.rx_data       = b;
        bus.rx_data_ready = 1'b1;
        bus.pkt_ack       = ack;
        @(negedge clk);
        bus.rx_data_ready = 1'b0;
        bus.pkt_ack       = 1'b0;
    endtask

    task automatic sendEop();
        bus.rx_endofpacket = 1'b1;
        @(negedge clk);
        bus.rx_endofpacket = 1'b0;
    endtask

    task automatic doAck();
        bus.pkt_ack = 1'b1;
        @(negedge clk);
        bus.pkt_ack = 1'b0;
        mPending = 1'b0;
        checkVal("ack_pending", 32'(bus.pkt_pending), 32'(mPending));
    endtask

    task automatic checkState(input string tag);
        checkVal($sformatf("%s_pending", tag), 32'(bus.pkt_pending), 32'(mPending));
        checkVal($sformatf("%s_len", tag), 32'(bus.pkt_len), 32'(mLen));
        checkVal($sformatf("%s_chkerr", tag), 32'(bus.chk_err_cnt), 32'(mChk));
        checkVal($sformatf("%s_frameerr", tag), 32'(bus.frame_err_cnt), 32'(mFrame));
        checkVal($sformatf("%s_overrun", tag), 32'(bus.overrun_cnt), 32'(mOvr));
        if (mPending) begin
            for (int a = 0; a < 16; a++) begin
                bus.rd_addr = 4'(a);
                #2;
                checkVal($sformatf("%s_rd%0d", tag, a), 32'(bus.rd_data), 32'(mBuf[a]));
                @(negedge clk);
            end
        end
    endtask

    // Sends SYNC, then `abortAt` bytes (or the whole frame) and predicts the result
    task automatic runFrame(input logic [7:0] lenByte, input byteQueue_t pl, input logic [7:0] chk,
                            input int abortAt, input bit ackOnChk, input int gapMax);
        bit         lenOk;
        int         total;
        bit         aborted;
        int         sent;
        logic [7:0] b;
        int         s;
        bit         pass;
        bit         p0;
        lenOk   = (lenByte >= 8'd1) && (int'(lenByte) <= MAXLEN);
        total   = lenOk ? int'(lenByte) + 2 : 1;
        aborted = abortAt < total;
        sent    = aborted ? abortAt : total;

        sendByte(SYNC, 1'b0);
        checkVal("valid_sync", 32'(bus.pkt_valid), 32'd0);
        for (int i = 0; i < sent; i++) begin
            repeat ($urandom_range(0, gapMax)) @(negedge clk);
            if (i == 0) b = lenByte;
            else if (i <= int'(lenByte)) b = pl[i-1];
            else b = chk;
            if (lenOk && i >= 1 && i <= int'(lenByte) && !mPending) mBuf[i-1] = pl[i-1];
            if (lenOk && i == total - 1) begin
                p0 = mPending;
                s  = int'(lenByte) + int'(chk);
                foreach (pl[k]) s += int'(pl[k]);
                pass = (s % 256) == 0;
                sendByte(b, ackOnChk);
                checkVal("valid_chk", 32'(bus.pkt_valid), 32'(pass && !p0));
                if (pass && !p0) begin
                    mPending = 1'b1;
                    mLen     = int'(lenByte);
                end else if (pass) begin
                    mOvr = sat(mOvr);
                end else begin
                    mChk = sat(mChk);
                end
                if (ackOnChk && p0) mPending = 1'b0;
            end else begin
                sendByte(b, 1'b0);
                checkVal("valid_byte", 32'(bus.pkt_valid), 32'd0);
            end
        end
        if (!lenOk && !aborted) mFrame = sat(mFrame);
        if (aborted) begin
            repeat ($urandom_range(0, gapMax)) @(negedge clk);
            sendEop();
            mFrame = sat(mFrame);
            checkVal("valid_abort", 32'(bus.pkt_valid), 32'd0);
        end
        checkState("frame");
    endtask

    task automatic sendJunk(input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom_range(0, 255));
            if (b == SYNC) b = 8'h55;
            sendByte(b, 1'b0);
            checkVal("valid_junk", 32'(bus.pkt_valid), 32'd0);
        end
    endtask

    initial begin
        byteQueue_t pl;
        logic [7:0] lenByte;
        logic [7:0] chk;
        int         kind;
        int         n;

        bus.rx_data        = 8'h00;
        bus.rx_data_ready  = 1'b0;
        bus.rx_endofpacket = 1'b0;
        bus.pkt_ack        = 1'b0;
        bus.rd_addr        = 4'd0;
        rst                = 1'b1;
        modelReset();
        #1;
        checkVal("reset_rd0", 32'(bus.rd_data), 32'd0);
        checkVal("reset_valid", 32'(bus.pkt_valid), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkState("reset");

        // Good frame then ack
        pl = {8'h10, 8'h20, 8'h30};
        runFrame(8'd3, pl, 8'h9D, 99, 1'b0, 0);
        doAck();
        doAck();

        // Hunt bytes then checksum error, then a one-byte frame
        sendByte(8'h55, 1'b0);
        sendByte(8'h00, 1'b0);
        runFrame(8'd3, pl, 8'h9E, 99, 1'b0, 1);
        pl = {8'h7F};
        runFrame(8'd1, pl, goodChk(8'd1, pl), 99, 1'b0, 1);
        doAck();

        // Abort mid-payload, zero length, over-length, then a good frame
        pl = {8'h10, 8'h20, 8'h30};
        runFrame(8'd3, pl, 8'h9D, 2, 1'b0, 0);
        sendEop();
        checkState("idle_eop");
        pl = {};
        runFrame(8'd0, pl, 8'h00, 99, 1'b0, 0);
        runFrame(8'd17, pl, 8'h00, 99, 1'b0, 0);
        pl = {8'h44, 8'h55};
        runFrame(8'd2, pl, goodChk(8'd2, pl), 99, 1'b0, 0);
        doAck();

        // Overrun: A held, B dropped, B again with ack on its checksum
        pl = {8'h01, 8'h02};
        runFrame(8'd2, pl, 8'hFB, 99, 1'b0, 0);
        pl = {8'h05, 8'h06};
        runFrame(8'd2, pl, 8'hF3, 99, 1'b0, 0);
        runFrame(8'd2, pl, 8'hF3, 99, 1'b1, 0);

        // Checksum error counter saturation
        for (int f = 0; f < 300; f++) begin
            pl = {8'($urandom_range(0, 255))};
            runFrame(8'd1, pl, goodChk(8'd1, pl) ^ 8'h01, 99, 1'b0, 0);
        end
        checkVal("chk_sat", 32'(bus.chk_err_cnt), 32'hFF);

        // Asynchronous reset in the middle of a payload
        sendByte(SYNC, 1'b0);
        sendByte(8'd4, 1'b0);
        sendByte(8'h11, 1'b0);
        sendByte(8'h22, 1'b0);
        bus.rd_addr = 4'd0;
        #2 rst = 1'b1;
        #1;
        modelReset();
        checkVal("rst_chkerr", 32'(bus.chk_err_cnt), 32'd0);
        checkVal("rst_frameerr", 32'(bus.frame_err_cnt), 32'd0);
        checkVal("rst_overrun", 32'(bus.overrun_cnt), 32'd0);
        checkVal("rst_pending", 32'(bus.pkt_pending), 32'd0);
        checkVal("rst_len", 32'(bus.pkt_len), 32'd0);
        checkVal("rst_rd0", 32'(bus.rd_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pl = {8'hC3, 8'h3C, 8'h5A};
        runFrame(8'd3, pl, goodChk(8'd3, pl), 99, 1'b0, 1);
        doAck();

        // Maximum length frame
        pl = {};
        for (int i = 0; i < 16; i++) pl.push_back(8'(i));
        runFrame(8'd16, pl, goodChk(8'd16, pl), 99, 1'b0, 0);
        doAck();

        // Randomized frame mix
        for (int f = 0; f < 300; f++) begin
            sendJunk($urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) sendEop();
            if ($urandom_range(0, 2) == 0) doAck();
            kind    = $urandom_range(0, 9);
            n       = $urandom_range(1, MAXLEN);
            lenByte = 8'(n);
            pl      = {};
            for (int i = 0; i < n; i++) pl.push_back(8'($urandom_range(0, 255)));
            chk = goodChk(lenByte, pl);
            case (kind)
                6: runFrame(lenByte, pl, chk ^ 8'($urandom_range(1, 255)), 99, 1'b0, 2);
                7: begin
                    n       = $urandom_range(0, 239);
                    lenByte = (n == 0) ? 8'd0 : 8'(n + 16);
                    pl      = {};
                    runFrame(lenByte, pl, 8'h00, 99, 1'b0, 2);
                end
                8: runFrame(lenByte, pl, chk, $urandom_range(0, n + 1), 1'b0, 2);
                9: runFrame(lenByte, pl, chk, 99, 1'b1, 2);
                default: runFrame(lenByte, pl, chk, 99, 1'b0, 2);
            endcase
        end
        doAck();
        checkState("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
